// File: rtl/rv_ctrl_pkg.sv
// Purpose: shared encodings for the multi-cycle RV control path (main FSM and alu_control).
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package rv_ctrl_pkg;

   // Controller states. The first ten are the architectural sequence.
   // S_FAULT is the single-cycle memory-timeout report state.
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEM_ADDR = 4'd2;
   localparam logic [3:0] S_MEM_RD   = 4'd3;
   localparam logic [3:0] S_MEM_WB   = 4'd4;
   localparam logic [3:0] S_MEM_WR   = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_R_WB     = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ILLEGAL  = 4'd9;
   localparam logic [3:0] S_FAULT    = 4'd10;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // alu_op encoding seen by alu_control
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU operand A / B source selects
   localparam logic       SRCA_PC   = 1'b0;
   localparam logic       SRCA_RS1  = 1'b1;
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // Opcode classification produced by ctrl_opcode_decode
   typedef enum logic [2:0] {
      CLS_LOAD    = 3'd0,
      CLS_STORE   = 3'd1,
      CLS_RTYPE   = 3'd2,
      CLS_BRANCH  = 3'd3,
      CLS_ILLEGAL = 3'd4
   } opc_class_t;

   // Full control-word bundle driven by the FSM each cycle
   typedef struct packed {
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       mem_to_reg;
      logic       instr_done;
      logic       illegal_instr;
      logic       mem_fault;
   } ctrl_t;

   // All strobes low, all selects at their zero encoding
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c = '0;
      return c;
   endfunction

   // States that hold while waiting for mem_ready and are timed by the wait counter
   function automatic logic is_wait_state(input logic [3:0] s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Purpose: classifies a 7-bit major opcode into load/store/rtype/branch/illegal.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever opcode is.
module ctrl_opcode_decode
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output opc_class_t opc_class,
   output logic       is_load,
   output logic       is_store,
   output logic       is_rtype,
   output logic       is_branch,
   output logic       is_illegal
);

   // Map the opcode onto one class; anything unrecognised is illegal
   always_comb begin
      opc_class = CLS_ILLEGAL;
      unique case (opcode)
         OP_LOAD:   opc_class = CLS_LOAD;
         OP_STORE:  opc_class = CLS_STORE;
         OP_RTYPE:  opc_class = CLS_RTYPE;
         OP_BRANCH: opc_class = CLS_BRANCH;
         default:   opc_class = CLS_ILLEGAL;
      endcase
   end

   assign is_load    = (opc_class == CLS_LOAD);
   assign is_store   = (opc_class == CLS_STORE);
   assign is_rtype   = (opc_class == CLS_RTYPE);
   assign is_branch  = (opc_class == CLS_BRANCH);
   assign is_illegal = (opc_class == CLS_ILLEGAL);

endmodule

// File: rtl/main_control_fsm.sv
// Purpose: multi-cycle RV main control FSM (fetch/decode/mem/exec/branch) with memory timeout.
// Latency: R-type 4, load 5, store 4, branch 3, illegal 3 cycles; +1 per memory wait cycle.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on mem_ready, abort to FETCH after MEM_TIMEOUT waits.
module main_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic [1:0] alu_op,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       reg_write,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal_instr,
   output logic       mem_fault
);

   // The counter value seen in the last permitted wait cycle; a miss here is the timeout
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [7:0] wait_cnt;
   logic [6:0] opc_q;
   logic [6:0] dec_opc;
   logic       waiting;
   logic       timeout;
   ctrl_t      ctrl;

   opc_class_t dec_class;
   logic       is_load;
   logic       is_store;
   logic       is_rtype;
   logic       is_branch;
   logic       is_illegal;

   // DECODE classifies the live opcode; later states reuse the copy latched in DECODE,
   // so one decoder serves both the dispatch and the load/store split in MEM_ADDR.
   assign dec_opc = (state == S_DECODE) ? opcode : opc_q;

   ctrl_opcode_decode u_decode (
      .opcode     (dec_opc),
      .opc_class  (dec_class),
      .is_load    (is_load),
      .is_store   (is_store),
      .is_rtype   (is_rtype),
      .is_branch  (is_branch),
      .is_illegal (is_illegal)
   );

   // mem_ready only matters in the three wait states; a ready on the timeout cycle wins
   assign waiting = is_wait_state(state);
   assign timeout = waiting && !mem_ready && (wait_cnt == TIMEOUT_LAST);

   // Next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: begin
            if (mem_ready)    state_nxt = S_DECODE;
            else if (timeout) state_nxt = S_FAULT;
         end
         S_DECODE: begin
            if (is_illegal)     state_nxt = S_ILLEGAL;
            else if (is_rtype)  state_nxt = S_EXEC_R;
            else if (is_branch) state_nxt = S_BRANCH;
            else                state_nxt = S_MEM_ADDR;
         end
         S_MEM_ADDR: begin
            if (is_store)     state_nxt = S_MEM_WR;
            else if (is_load) state_nxt = S_MEM_RD;
            else              state_nxt = S_FETCH;
         end
         S_MEM_RD: begin
            if (mem_ready)    state_nxt = S_MEM_WB;
            else if (timeout) state_nxt = S_FAULT;
         end
         S_MEM_WR: begin
            if (mem_ready)    state_nxt = S_FETCH;
            else if (timeout) state_nxt = S_FAULT;
         end
         S_EXEC_R:  state_nxt = S_R_WB;
         S_MEM_WB,
         S_R_WB,
         S_BRANCH,
         S_ILLEGAL,
         S_FAULT:   state_nxt = S_FETCH;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // State, wait counter and opcode latch
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= 8'd0;
         opc_q    <= 7'd0;
      end else begin
         state <= state_nxt;
         // Every transition clears the counter, which covers entry into each wait state
         if (state_nxt != state)
            wait_cnt <= 8'd0;
         else if (waiting && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
         if (state == S_DECODE)
            opc_q <= opcode;
      end
   end

   // Control word: Moore per state, except the FETCH loads and store completion follow mem_ready
   always_comb begin
      ctrl = ctrl_idle();
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_PC;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b0;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = SRCA_RS1;
            ctrl.alu_src_b     = SRCB_RS2;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.instr_done    = 1'b1;
         end
         S_ILLEGAL: begin
            ctrl.illegal_instr = 1'b1;
         end
         S_FAULT: begin
            ctrl.mem_fault = 1'b1;
         end
         default: ctrl = ctrl_idle();
      endcase
      // Held reset silences everything; release shows FETCH immediately
      if (rst)
         ctrl = ctrl_idle();
   end

   assign alu_op        = ctrl.alu_op;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign reg_write     = ctrl.reg_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign instr_done    = ctrl.instr_done;
   assign illegal_instr = ctrl.illegal_instr;
   assign mem_fault     = ctrl.mem_fault;

endmodule

// File: tb/tb_main_control_fsm.sv
// Purpose: self-checking bench for main_control_fsm: directed scenarios plus random instruction stream.
// Latency: every cycle's outputs compared against a per-instruction expected trace.
// Backpressure: mem_ready wait lengths drawn per instruction, including timeouts.
module tb_main_control_fsm;

   localparam int T = 4;

   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] ILL = 7'b0010011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic       mem_ready = 1'b0;
   logic [1:0] alu_op;
   logic       mem_read, mem_write, ir_write, pc_write, pc_write_cond;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       reg_write, mem_to_reg, instr_done, illegal_instr, mem_fault;

   int n_vec = 0;
   int n_err = 0;

   // Per-cycle plan: inputs to apply and the output word expected in that cycle
   bit          q_rst[$];
   bit          q_mr[$];
   logic [6:0]  q_opc[$];
   logic [14:0] q_exp[$];
   string       q_tag[$];

   always #5 clk = ~clk;

   main_control_fsm #(.MEM_TIMEOUT(T)) dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .alu_op        (alu_op),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .instr_done    (instr_done),
      .illegal_instr (illegal_instr),
      .mem_fault     (mem_fault)
   );

   // Output word order: alu_op,rd,wr,ir,pc,pcc,src_a,src_b,rw,m2r,done,ill,flt
   function automatic logic [14:0] ov(input logic [1:0] aop, input logic rd, input logic wr,
                                      input logic irw, input logic pcw, input logic pcc,
                                      input logic sa, input logic [1:0] sb, input logic rw,
                                      input logic m2r, input logic dn, input logic ill,
                                      input logic flt);
      return {aop, rd, wr, irw, pcw, pcc, sa, sb, rw, m2r, dn, ill, flt};
   endfunction

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   function automatic logic [6:0] rop();
      return 7'($urandom);
   endfunction

   task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b want %b (aop,rd,wr,ir,pc,pcc,sa,sb,rw,m2r,done,ill,flt)",
                  tag, $time, got, exp);
      end
   endtask

   task automatic push(input bit r, input bit m, input logic [6:0] o, input logic [14:0] e,
                       input string t);
      q_rst.push_back(r);
      q_mr.push_back(m);
      q_opc.push_back(o);
      q_exp.push_back(e);
      q_tag.push_back(t);
   endtask

   // A memory wait phase: w cycles without ready, then either completion or timeout report
   task automatic plan_wait(input int w, input logic [14:0] busy, input logic [14:0] done,
                            input string t, output bit ok);
      int n;
      n = (w < T) ? w : T;
      for (int i = 0; i < n; i++) push(1'b0, 1'b0, rop(), busy, {t, "_wait"});
      if (w >= T) begin
         push(1'b0, rb(), rop(), ov(2'b00,0,0,0,0,0,0,2'b00,0,0,0,0,1), {t, "_fault"});
         ok = 1'b0;
      end else begin
         push(1'b0, 1'b1, rop(), done, {t, "_ready"});
         ok = 1'b1;
      end
   endtask

   // One instruction from FETCH back to FETCH, given fetch and data-memory wait counts
   task automatic plan_instr(input logic [6:0] op, input int wf, input int wm);
      bit ok;
      plan_wait(wf, ov(2'b00,1,0,0,0,0,0,2'b01,0,0,0,0,0),
                    ov(2'b00,1,0,1,1,0,0,2'b01,0,0,0,0,0), "fetch", ok);
      if (!ok) return;
      push(1'b0, rb(), op, ov(2'b00,0,0,0,0,0,0,2'b10,0,0,0,0,0), "decode");
      if (op == RT) begin
         push(1'b0, rb(), rop(), ov(2'b10,0,0,0,0,0,1,2'b00,0,0,0,0,0), "exec_r");
         push(1'b0, rb(), rop(), ov(2'b00,0,0,0,0,0,0,2'b00,1,0,1,0,0), "r_wb");
      end else if (op == BR) begin
         push(1'b0, rb(), rop(), ov(2'b01,0,0,0,0,1,1,2'b00,0,0,1,0,0), "branch");
      end else if (op == LD) begin
         push(1'b0, rb(), rop(), ov(2'b00,0,0,0,0,0,1,2'b10,0,0,0,0,0), "mem_addr");
         plan_wait(wm, ov(2'b00,1,0,0,0,0,0,2'b00,0,0,0,0,0),
                       ov(2'b00,1,0,0,0,0,0,2'b00,0,0,0,0,0), "mem_rd", ok);
         if (ok) push(1'b0, rb(), rop(), ov(2'b00,0,0,0,0,0,0,2'b00,1,1,1,0,0), "mem_wb");
      end else if (op == ST) begin
         push(1'b0, rb(), rop(), ov(2'b00,0,0,0,0,0,1,2'b10,0,0,0,0,0), "mem_addr");
         plan_wait(wm, ov(2'b00,0,1,0,0,0,0,2'b00,0,0,0,0,0),
                       ov(2'b00,0,1,0,0,0,0,2'b00,0,0,1,0,0), "mem_wr", ok);
      end else begin
         push(1'b0, rb(), rop(), ov(2'b00,0,0,0,0,0,0,2'b00,0,0,0,1,0), "illegal");
      end
   endtask

   function automatic int rwait();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(T, T + 1));
      return int'($urandom_range(0, T - 1));
   endfunction

   function automatic logic [6:0] pick_op();
      case ($urandom_range(0, 5))
         0: return LD;
         1: return ST;
         2: return RT;
         3: return BR;
         4: return ILL;
         default: return rop();
      endcase
   endfunction

   initial begin
      bit ok;
      // Reset held two cycles: all outputs low
      push(1'b1, rb(), rop(), '0, "reset");
      push(1'b1, rb(), rop(), '0, "reset");
      // Directed scenarios
      plan_instr(RT, 0, 0);
      plan_instr(LD, 0, 2);
      plan_instr(BR, 0, 0);
      plan_instr(ILL, 0, 0);
      plan_instr(ST, 0, T);       // timeout in MEM_WR
      plan_instr(ST, 0, T - 1);   // ready on the last permitted cycle
      plan_instr(LD, 0, T);       // timeout in MEM_RD
      plan_instr(RT, T, 0);       // timeout in FETCH
      plan_instr(ST, 1, 0);
      // Reset in the middle of a MEM_RD wait
      plan_wait(0, ov(2'b00,1,0,0,0,0,0,2'b01,0,0,0,0,0),
                   ov(2'b00,1,0,1,1,0,0,2'b01,0,0,0,0,0), "fetch", ok);
      push(1'b0, 1'b1, LD, ov(2'b00,0,0,0,0,0,0,2'b10,0,0,0,0,0), "decode");
      push(1'b0, 1'b1, rop(), ov(2'b00,0,0,0,0,0,1,2'b10,0,0,0,0,0), "mem_addr");
      push(1'b0, 1'b0, rop(), ov(2'b00,1,0,0,0,0,0,2'b00,0,0,0,0,0), "mem_rd_wait");
      push(1'b0, 1'b0, rop(), ov(2'b00,1,0,0,0,0,0,2'b00,0,0,0,0,0), "mem_rd_wait");
      push(1'b1, 1'b1, rop(), '0, "rst_mid_wait");
      plan_instr(LD, 0, T - 1);   // counter must start from zero after reset
      // Random instruction stream
      for (int i = 0; i < 300; i++) plan_instr(pick_op(), rwait(), rwait());

      while (q_exp.size() > 0) begin
         logic [14:0] e;
         string       t;
         @(negedge clk);
         rst       = q_rst.pop_front();
         mem_ready = q_mr.pop_front();
         opcode    = q_opc.pop_front();
         e         = q_exp.pop_front();
         t         = q_tag.pop_front();
         #2;
         chk(t, {alu_op, mem_read, mem_write, ir_write, pc_write, pc_write_cond, alu_src_a,
                 alu_src_b, reg_write, mem_to_reg, instr_done, illegal_instr, mem_fault}, e);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
